cntr8_sched: RTL and testbench

Command scheduler for the 8-bit up/down counter datapath (cntr8). It lets two independent requesters share one counter. It takes LOAD, INC-burst and DEC-burst commands through a req/gnt/done handshake and arbitrates round-robin between the requesters. It then sequences the counter's load/inc controls and clock-enable for exactly the required number of cycles.

---
 rtl/cntr8_sched.sv | 147 ++++++++++++++
 tb/tb_cntr8_sched.sv | 220 ++++++++++++++++++++++
 2 files changed

// File: rtl/cntr8_sched.sv
// Round-robin command scheduler for two requesters sharing one up/down counter.
// Every output is a flop written together with the state, so no input reaches an output combinationally.
module cntr8_sched #(
  parameter int W  = 8,
  parameter int LW = 4
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          req0,
  input  logic          req1,
  input  logic [1:0]    cmd0,
  input  logic [1:0]    cmd1,
  input  logic [W-1:0]  val0,
  input  logic [W-1:0]  val1,
  input  logic [LW-1:0] len0,
  input  logic [LW-1:0] len1,
  output logic          gnt0,
  output logic          gnt1,
  output logic          done0,
  output logic          done1,
  output logic          busy,
  output logic          cnt_en,
  output logic          cnt_load,
  output logic          cnt_inc,
  output logic [W-1:0]  cnt_d
);

  localparam logic [1:0] C_NOP  = 2'b00;
  localparam logic [1:0] C_LOAD = 2'b01;
  localparam logic [1:0] C_INC  = 2'b10;

  typedef enum logic [1:0] {S_IDLE, S_GRANT, S_RUN, S_DONE} state_t;

  state_t        r_state;
  logic [1:0]    r_cmd;
  logic [W-1:0]  r_val;
  logic [LW-1:0] r_step;
  logic          r_win;
  logic          r_last;
  logic          r_gnt0, r_gnt1, r_done0, r_done1, r_busy;
  logic          r_cnt_en, r_cnt_load, r_cnt_inc;
  logic [W-1:0]  r_cnt_d;

  logic w_pick1;
  logic w_any;
  logic w_is_load;
  logic w_is_inc;

  // On a tie the requester not served last wins; r_last=1 means req1 was served last.
  assign w_pick1   = req1 & (~req0 | ~r_last);
  assign w_any     = req0 | req1;
  assign w_is_load = (r_cmd == C_LOAD);
  assign w_is_inc  = (r_cmd == C_INC);

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state    <= S_IDLE;
      r_cmd      <= C_NOP;
      r_val      <= '0;
      r_step     <= '0;
      r_win      <= 1'b0;
      r_last     <= 1'b1;
      r_gnt0     <= 1'b0;
      r_gnt1     <= 1'b0;
      r_done0    <= 1'b0;
      r_done1    <= 1'b0;
      r_busy     <= 1'b0;
      r_cnt_en   <= 1'b0;
      r_cnt_load <= 1'b0;
      r_cnt_inc  <= 1'b0;
      r_cnt_d    <= '0;
    end else begin
      r_gnt0     <= 1'b0;
      r_gnt1     <= 1'b0;
      r_done0    <= 1'b0;
      r_done1    <= 1'b0;
      r_busy     <= 1'b1;
      r_cnt_en   <= 1'b0;
      r_cnt_load <= 1'b0;
      r_cnt_inc  <= 1'b0;
      r_cnt_d    <= '0;
      case (r_state)
        S_IDLE: begin
          if (w_any) begin
            r_state <= S_GRANT;
            r_win   <= w_pick1;
            r_last  <= w_pick1;
            r_cmd   <= w_pick1 ? cmd1 : cmd0;
            r_val   <= w_pick1 ? val1 : val0;
            r_step  <= w_pick1 ? len1 : len0;
            r_gnt0  <= ~w_pick1;
            r_gnt1  <= w_pick1;
          end else begin
            r_busy  <= 1'b0;
          end
        end
        S_GRANT: begin
          if (r_cmd == C_NOP) begin
            r_state <= S_DONE;
            r_done0 <= ~r_win;
            r_done1 <= r_win;
          end else begin
            r_state    <= S_RUN;
            r_cnt_en   <= 1'b1;
            r_cnt_load <= w_is_load;
            r_cnt_inc  <= w_is_inc;
            r_cnt_d    <= w_is_load ? r_val : '0;
            // A load is a single step regardless of the latched length.
            if (w_is_load) r_step <= '0;
          end
        end
        S_RUN: begin
          if (r_step == '0) begin
            r_state <= S_DONE;
            r_done0 <= ~r_win;
            r_done1 <= r_win;
          end else begin
            r_step     <= r_step - LW'(1);
            r_cnt_en   <= 1'b1;
            r_cnt_load <= w_is_load;
            r_cnt_inc  <= w_is_inc;
            r_cnt_d    <= w_is_load ? r_val : '0;
          end
        end
        S_DONE: begin
          r_state <= S_IDLE;
          r_busy  <= 1'b0;
        end
        default: begin
          r_state <= S_IDLE;
          r_busy  <= 1'b0;
        end
      endcase
    end
  end

  assign gnt0     = r_gnt0;
  assign gnt1     = r_gnt1;
  assign done0    = r_done0;
  assign done1    = r_done1;
  assign busy     = r_busy;
  assign cnt_en   = r_cnt_en;
  assign cnt_load = r_cnt_load;
  assign cnt_inc  = r_cnt_inc;
  assign cnt_d    = r_cnt_d;

endmodule

// File: tb/tb_cntr8_sched.sv
// Bench for cntr8_sched: command table plus hand-written sequences, with a counter
// model and a done-time scoreboard.
module tb_cntr8_sched;
  localparam int W  = 8;
  localparam int LW = 4;

  logic          clk = 1'b0;
  logic          reset;
  logic          req0, req1;
  logic [1:0]    cmd0, cmd1;
  logic [W-1:0]  val0, val1;
  logic [LW-1:0] len0, len1;
  logic          gnt0, gnt1, done0, done1, busy, cnt_en, cnt_load, cnt_inc;
  logic [W-1:0]  cnt_d;

  cntr8_sched #(.W(W), .LW(LW)) dut (
    .clk(clk), .reset(reset),
    .req0(req0), .req1(req1), .cmd0(cmd0), .cmd1(cmd1),
    .val0(val0), .val1(val1), .len0(len0), .len1(len1),
    .gnt0(gnt0), .gnt1(gnt1), .done0(done0), .done1(done1), .busy(busy),
    .cnt_en(cnt_en), .cnt_load(cnt_load), .cnt_inc(cnt_inc), .cnt_d(cnt_d)
  );

  always #5 clk = ~clk;

  typedef struct {
    int         who;
    logic [1:0] cmd;
    logic [7:0] val;
    logic [3:0] len;
    int         exp_en;
    logic [7:0] exp_end;
  } vec_t;

  int   checks = 0;
  int   failures = 0;
  vec_t sb[$];
  logic [7:0] m_cnt;
  int   en_cnt = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h t=%0t", name, act, exp, $time);
    end
  endtask

  // The counter datapath being driven: it moves only on edges with cnt_en.
  always @(posedge clk)
    if (cnt_en) m_cnt <= cnt_load ? cnt_d : (cnt_inc ? m_cnt + 8'd1 : m_cnt - 8'd1);

  always @(negedge clk) begin
    if (!reset) begin
      chk("one_gnt", 32'(gnt0 & gnt1), 0);
      if (gnt0 | gnt1) en_cnt = 0;
      if (cnt_en) begin
        en_cnt++;
        if (sb.size() > 0) begin
          chk("run_load", 32'(cnt_load), 32'(sb[0].cmd == 2'b01));
          chk("run_inc", 32'(cnt_inc), 32'(sb[0].cmd == 2'b10));
          if (sb[0].cmd == 2'b01) chk("run_d", 32'(cnt_d), 32'(sb[0].val));
        end
      end else begin
        chk("idle_ctl", {22'd0, cnt_load, cnt_inc, cnt_d}, 0);
      end
      if (done0 | done1) begin
        chk("done_expected", sb.size(), 1 + (sb.size() > 1 ? sb.size() - 1 : 0));
        if (sb.size() > 0) begin
          vec_t e;
          e = sb.pop_front();
          chk("done_who", {30'd0, done1, done0}, (e.who == 1) ? 2 : 1);
          chk("en_cycles", en_cnt, e.exp_en);
          chk("cnt_end", 32'(m_cnt), 32'(e.exp_end));
        end
      end
    end
  end

  task automatic drive(input int who, input logic r, input logic [1:0] c, input logic [7:0] v, input logic [3:0] l);
    if (who == 0) begin req0 = r; cmd0 = c; val0 = v; len0 = l; end
    else          begin req1 = r; cmd1 = c; val1 = v; len1 = l; end
  endtask

  task automatic wait_idle();
    int n = 0;
    while (busy !== 1'b0 && n < 60) begin @(posedge clk); #1; n++; end
    chk("idle_timeout", 32'(busy), 0);
  endtask

  task automatic issue(input vec_t v);
    int n = 0;
    wait_idle();
    drive(v.who, 1'b1, v.cmd, v.val, v.len);
    sb.push_back(v);
    @(posedge clk); #1;
    chk("gnt_mine", 32'(v.who == 0 ? gnt0 : gnt1), 1);
    chk("gnt_other", 32'(v.who == 0 ? gnt1 : gnt0), 0);
    drive(v.who, 1'b0, 2'b00, 8'h00, 4'h0);
    while (!(done0 | done1) && n < 40) begin @(posedge clk); #1; n++; end
    chk("done_lat", n, v.exp_en + 1);
  endtask

  task automatic drain(input string name);
    int n = 0;
    while (sb.size() > 0 && n < 40) begin @(posedge clk); #1; n++; end
    chk(name, sb.size(), 0);
  endtask

  vec_t tbl[9];
  int   order[3];

  initial begin
    #500000;
    $display("FAIL watchdog expired checks=%0d", checks);
    $fatal(1);
  end

  initial begin
    int g, n;
    reset = 1'b1;
    drive(0, 1'b0, 2'b00, 8'h00, 4'h0);
    drive(1, 1'b0, 2'b00, 8'h00, 4'h0);
    repeat (3) @(posedge clk);
    #1;
    chk("reset_outs", {gnt0, gnt1, done0, done1, busy, cnt_en, cnt_load, cnt_inc, cnt_d}, 0);
    reset = 1'b0;

    tbl[0] = '{0, 2'b01, 8'hA5, 4'd0,  1,  8'hA5};
    tbl[1] = '{1, 2'b01, 8'hFE, 4'd0,  1,  8'hFE};
    tbl[2] = '{1, 2'b10, 8'h00, 4'd3,  4,  8'h02};
    tbl[3] = '{0, 2'b11, 8'h00, 4'd1,  2,  8'h00};
    tbl[4] = '{0, 2'b11, 8'h00, 4'd0,  1,  8'hFF};
    tbl[5] = '{1, 2'b00, 8'h77, 4'd9,  0,  8'hFF};
    tbl[6] = '{0, 2'b10, 8'h00, 4'd15, 16, 8'h0F};
    tbl[7] = '{1, 2'b01, 8'h00, 4'd7,  1,  8'h00};
    tbl[8] = '{0, 2'b11, 8'h00, 4'd4,  5,  8'hFB};
    for (int i = 0; i < 9; i++) issue(tbl[i]);
    drain("table_drain");

    // Contention: both hold req with 2-step DECs after req1 was served last.
    issue('{1, 2'b01, 8'h10, 4'd0, 1, 8'h10});
    drain("setup_drain");
    wait_idle();
    drive(0, 1'b1, 2'b11, 8'h00, 4'd1);
    drive(1, 1'b1, 2'b11, 8'h00, 4'd1);
    sb.push_back('{0, 2'b11, 8'h00, 4'd1, 2, 8'h0E});
    sb.push_back('{1, 2'b11, 8'h00, 4'd1, 2, 8'h0C});
    sb.push_back('{0, 2'b11, 8'h00, 4'd1, 2, 8'h0A});
    g = 0; n = 0;
    while (g < 3 && n < 80) begin
      @(posedge clk); #1; n++;
      if (gnt0 | gnt1) begin
        order[g] = gnt1 ? 1 : 0;
        g++;
        if (g == 3) begin
          drive(0, 1'b0, 2'b00, 8'h00, 4'h0);
          drive(1, 1'b0, 2'b00, 8'h00, 4'h0);
        end
      end
    end
    chk("cont_grants", g, 3);
    chk("cont_order0", order[0], 0);
    chk("cont_order1", order[1], 1);
    chk("cont_order2", order[2], 0);
    drain("cont_drain");

    // NOP from req0, then req1 raised during the DONE cycle.
    wait_idle();
    drive(0, 1'b1, 2'b00, 8'h00, 4'd3);
    sb.push_back('{0, 2'b00, 8'h00, 4'd3, 0, m_cnt});
    @(posedge clk); #1;
    chk("nop_gnt0", 32'(gnt0), 1);
    drive(0, 1'b0, 2'b00, 8'h00, 4'h0);
    @(posedge clk); #1;
    chk("nop_done0", 32'(done0), 1);
    drive(1, 1'b1, 2'b01, 8'h33, 4'd0);
    sb.push_back('{1, 2'b01, 8'h33, 4'd0, 1, 8'h33});
    @(posedge clk); #1;
    chk("late_not_yet", {30'd0, gnt1, busy}, 0);
    @(posedge clk); #1;
    chk("late_gnt1", 32'(gnt1), 1);
    drive(1, 1'b0, 2'b00, 8'h00, 4'h0);
    drain("late_drain");

    // Reset in the middle of a req0 DEC burst, then a tie must go to req0.
    wait_idle();
    drive(0, 1'b1, 2'b11, 8'h00, 4'd5);
    @(posedge clk); #1;
    chk("abort_gnt0", 32'(gnt0), 1);
    drive(0, 1'b0, 2'b00, 8'h00, 4'h0);
    repeat (3) @(posedge clk);
    #1;
    chk("abort_running", 32'(cnt_en), 1);
    reset = 1'b1;
    @(posedge clk); #1;
    chk("abort_outs", {27'd0, busy, cnt_en, done0, done1, gnt0}, 0);
    reset = 1'b0;
    repeat (6) begin
      @(posedge clk); #1;
      chk("abort_quiet", {29'd0, busy, done0, done1}, 0);
    end
    drive(0, 1'b1, 2'b00, 8'h00, 4'd0);
    drive(1, 1'b1, 2'b00, 8'h00, 4'd0);
    sb.push_back('{0, 2'b00, 8'h00, 4'd0, 0, m_cnt});
    sb.push_back('{1, 2'b00, 8'h00, 4'd0, 0, m_cnt});
    @(posedge clk); #1;
    chk("tie_gnt", {30'd0, gnt1, gnt0}, 1);
    drive(0, 1'b0, 2'b00, 8'h00, 4'h0);
    n = 0;
    while (!gnt1 && n < 12) begin @(posedge clk); #1; n++; end
    chk("b2b_lat", n, 3);
    drive(1, 1'b0, 2'b00, 8'h00, 4'h0);
    drain("tie_drain");

    repeat (2) @(posedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
